uart_telemetry_arbiter: RTL

// Shares the single uart_tx transmitter between NUM_SRC telemetry FIFOs, e.g. the IR/PID-error FIFO and the motor duty-cycle FIFO.

---
 rtl/uart_telemetry_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/uart_telemetry_arbiter.sv
// Round-robin arbiter sharing one uart_tx between NUM_SRC telemetry FIFOs.
// Each popped word goes out as a header byte {HDR_TAG, id} followed by the word bytes MSB first.
module uart_telemetry_arbiter #(
  parameter int          NUM_SRC    = 2,
  parameter int          WORD_BYTES = 8,
  parameter logic [3:0]  HDR_TAG    = 4'hA,
  localparam int         GW         = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          en,
  input  logic [NUM_SRC-1:0]            src_empty,
  input  logic [NUM_SRC*8*WORD_BYTES-1:0] src_data,
  output logic [NUM_SRC-1:0]            src_rd_en,
  output logic                          uart_start_tx,
  output logic [7:0]                    uart_tx_din,
  input  logic                          uart_tx_done,
  output logic                          busy,
  output logic [GW-1:0]                 grant_id
);

  // state  | meaning
  // IDLE   | waiting for en and a non-empty FIFO; pops the winner
  // CAPT   | FIFO dout valid, latch word and prepare header byte
  // HDR    | start header byte
  // WAIT   | byte in flight; on done send next word byte or finish
  // DONE   | advance round-robin pointer, drop busy
  typedef enum logic [2:0] {S_IDLE, S_CAPT, S_HDR, S_WAIT, S_DONE} state_t;

  localparam int DW = 8 * WORD_BYTES;
  localparam int CW = $clog2(WORD_BYTES + 1);

  state_t          state, state_nxt;
  logic [GW-1:0]   rr_ptr;
  logic [GW-1:0]   gnt_idx;
  logic [GW-1:0]   cand;
  logic            gnt_found;
  logic            fire;
  logic [DW-1:0]   word_reg;
  logic [CW-1:0]   byte_cnt;
  logic            start_pend;
  logic            last_byte;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = GW'((int'(rr_ptr) + k) % NUM_SRC);
      if (!gnt_found && !src_empty[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign fire      = (state == S_IDLE) && en && gnt_found;
  assign last_byte = (byte_cnt == CW'(WORD_BYTES));

  // Gated by reset_n so a FIFO is never popped while the block is held in reset.
  assign src_rd_en     = (fire && reset_n) ? (NUM_SRC'(1) << gnt_idx) : '0;
  assign uart_start_tx = (state == S_HDR) || start_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (fire) state_nxt = S_CAPT;
      S_CAPT: state_nxt = S_HDR;
      S_HDR:  state_nxt = S_WAIT;
      S_WAIT: if (uart_tx_done && last_byte) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr      <= GW'(NUM_SRC - 1);
      grant_id    <= '0;
      busy        <= 1'b0;
      word_reg    <= '0;
      uart_tx_din <= '0;
      byte_cnt    <= '0;
      start_pend  <= 1'b0;
    end else begin
      start_pend <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fire) begin
            grant_id <= gnt_idx;
            busy     <= 1'b1;
          end
        end
        S_CAPT: begin
          word_reg    <= src_data[grant_id*DW +: DW];
          uart_tx_din <= {HDR_TAG, 4'(grant_id)};
          byte_cnt    <= '0;
        end
        S_WAIT: begin
          // Word is shifted left so the next byte to send is always the top one.
          if (uart_tx_done && !last_byte) begin
            uart_tx_din <= word_reg[DW-1 -: 8];
            word_reg    <= word_reg << 8;
            byte_cnt    <= byte_cnt + CW'(1);
            start_pend  <= 1'b1;
          end
        end
        S_DONE: begin
          rr_ptr <= grant_id;
          busy   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
